// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for a synchronous FIFO with one-cycle read
// latency. It issues rd whenever the FIFO is non-empty and the 2-entry skid
// buffer has room. Words are presented in order on a valid/ready stream.
//
// Optional feature: define FIFO_READER_COUNT_EN to add the word_count port and
// its delivered-word counter.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   en                  enables new reads; buffered/in-flight words still drain
//   outEmpty            FIFO empty flag
//   errorEmpty          FIFO underflow flag
//   data_out            FIFO read data, valid the cycle after rd is sampled
//   rd                  FIFO read strobe (combinational)
//   data_o, valid_o     head word of skid buffer and its valid flag
//   ready_i             downstream accepts data_o this cycle
//   err_o               sticky underflow indicator
//   word_count          words delivered (FIFO_READER_COUNT_EN only)
module fifo_reader #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  outEmpty,
  input  logic                  errorEmpty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  err_o
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] word_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  occ_t                  occ_next;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic                  tail_is_head;
  logic [2:0]            credit;

  assign pop    = valid_o & ready_i;
  assign data_o = buf0;

  // Words owed to the buffer after this cycle; pop only happens with occ != 0,
  // so the subtraction cannot underflow.
  assign credit = 3'(occ) + 3'(inflight) - 3'(pop);
  assign rd     = en & ~outEmpty & ~reset & (credit < 3'd2);

  // A pushed word lands in buf0 when the buffer is empty after this cycle's pop.
  assign tail_is_head = (occ == EMPTY) || ((occ == ONE) && pop);

  // Occupancy update from push (in-flight word arriving) and pop.
  always_comb begin
    occ_next = occ;
    case (occ)
      EMPTY: if (inflight) occ_next = ONE;
      ONE: begin
        if (inflight && !pop)      occ_next = TWO;
        else if (!inflight && pop) occ_next = EMPTY;
      end
      TWO:     if (pop && !inflight) occ_next = ONE;
      default: occ_next = EMPTY;
    endcase
  end

  // Skid buffer, occupancy, in-flight tracking and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= EMPTY;
      inflight <= 1'b0;
      valid_o  <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      err_o    <= 1'b0;
    end else begin
      occ      <= occ_next;
      valid_o  <= (occ_next != EMPTY);
      inflight <= rd;
      err_o    <= err_o | errorEmpty;
      if (pop) buf0 <= buf1;
      // Later assignment wins, so a push into buf0 overrides the shift.
      if (inflight) begin
        if (tail_is_head) buf0 <= data_out;
        else              buf1 <= data_out;
      end
    end
  end

`ifdef FIFO_READER_COUNT_EN
  // Delivered-word counter, wraps naturally at 2^COUNT_WIDTH.
  always_ff @(posedge clk) begin
    if (reset)    word_count <= '0;
    else if (pop) word_count <= word_count + COUNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO model on the read port.
module tb_fifo_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          outEmpty;
  logic          errorEmpty;
  logic [DW-1:0] data_out;
  logic          rd;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          err_o;
`ifdef FIFO_READER_COUNT_EN
  logic [CW-1:0] word_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] fq[$];
  logic [7:0] got[$];
  logic       s_rd;
  logic       s_valid;
  logic       s_pop;
  logic [7:0] s_data;
  int         rd_cnt;

  fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .outEmpty  (outEmpty),
    .errorEmpty(errorEmpty),
    .data_out  (data_out),
    .rd        (rd),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .err_o     (err_o)
`ifdef FIFO_READER_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock: sample DUT on the falling edge, then model the FIFO read port.
  task automatic tick();
    @(negedge clk);
    s_rd    = rd;
    s_valid = valid_o;
    s_data  = data_o;
    s_pop   = valid_o && ready_i;
    if (s_pop) got.push_back(data_o);
    if (s_rd) rd_cnt++;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0) data_out = fq.pop_front();
    outEmpty = (fq.size() == 0);
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
    outEmpty = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; outEmpty = 1'b0; ready_i = 1'b1;
    errorEmpty = 1'b0; data_out = 8'h00;
    tick();
    tick();
    total++; if (s_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", s_rd); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
    reset = 1'b0; en = 1'b0;
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", valid_o); end
  endtask

  task automatic test_basic();
    logic [5:0] exp_rd;
    logic [5:0] exp_v;
    logic [7:0] exp_d [6];
    exp_rd = 6'b000111;
    exp_v  = 6'b011100;
    exp_d  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    got.delete();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    outEmpty = 1'b0; en = 1'b1; ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (s_rd !== exp_rd[k]) begin
        bad++; $display("FAIL basic_rd[%0d] got=%b exp=%b", k, s_rd, exp_rd[k]);
      end
      total++;
      if (s_valid !== exp_v[k]) begin
        bad++; $display("FAIL basic_valid[%0d] got=%b exp=%b", k, s_valid, exp_v[k]);
      end
      if (exp_v[k]) begin
        total++;
        if (s_data !== exp_d[k]) begin
          bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", k, s_data, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    got.delete(); rd_cnt = 0;
    ready_i = 1'b0; en = 1'b1;
    load(8'hA1, 5);
    for (int k = 0; k < 6; k++) tick();
    total++; if (rd_cnt !== 2) begin bad++; $display("FAIL bp_rd_count got=%0d exp=2", rd_cnt); end
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", s_valid); end
    total++; if (s_data !== 8'hA1) begin bad++; $display("FAIL bp_head got=%h exp=a1", s_data); end
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 5) begin
        total++;
        if (s_valid !== 1'b1 || s_data !== 8'hA1 + 8'(k)) begin
          bad++; $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h", k, s_valid, s_data, 8'hA1 + 8'(k));
        end
      end else begin
        total++;
        if (s_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", s_valid); end
      end
    end
  endtask

  task automatic test_push_pop();
    int outst;
    logic phase;
    outst = 0; phase = 1'b0;
    got.delete();
    en = 1'b1;
    load(8'h40, 10);
    for (int i = 0; i < 80 && got.size() < 10; i++) begin
      ready_i = phase;
      tick();
      phase = ~phase;
      outst = outst + (s_rd ? 1 : 0) - (s_pop ? 1 : 0);
      total++;
      if (outst > 2) begin bad++; $display("FAIL pp_outstanding got=%0d exp<=2", outst); end
    end
    ready_i = 1'b1;
    total++; if (got.size() != 10) begin bad++; $display("FAIL pp_count got=%0d exp=10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 8'h40 + 8'(i)) begin
        bad++; $display("FAIL pp_order[%0d] got=%h exp=%h", i, got[i], 8'h40 + 8'(i));
      end
    end
  endtask

  task automatic test_en_drop();
    got.delete(); rd_cnt = 0;
    ready_i = 1'b1; en = 1'b1;
    load(8'h51, 3);
    tick();
    en = 1'b0;
    tick();
    total++; if (s_rd !== 1'b0) begin bad++; $display("FAIL en_drop_rd got=%b exp=0", s_rd); end
    tick();
    tick();
    total++; if (rd_cnt !== 1) begin bad++; $display("FAIL en_drop_rdcnt got=%0d exp=1", rd_cnt); end
    total++;
    if (got.size() != 1 || got[0] !== 8'h51) begin
      bad++; $display("FAIL en_drop_inflight got=%0d words exp=1 word 51", got.size());
    end
    en = 1'b1;
    run_until(3, 20);
    total++; if (rd_cnt !== 3) begin bad++; $display("FAIL en_resume_rdcnt got=%0d exp=3", rd_cnt); end
    total++;
    if (got.size() != 3 || got[1] !== 8'h52 || got[2] !== 8'h53) begin
      bad++; $display("FAIL en_resume_order got=%0d words exp=3 (51 52 53)", got.size());
    end
  endtask

  task automatic test_reset_mid();
    got.delete();
    ready_i = 1'b0; en = 1'b1;
    load(8'h61, 6);
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++; if (s_rd !== 1'b0) begin bad++; $display("FAIL rst_mid_rd got=%b exp=0", s_rd); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", valid_o); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL rst_mid_rd_hold got=%b exp=0", rd); end
    reset = 1'b0; ready_i = 1'b1;
    run_until(4, 30);
    total++; if (got.size() != 4) begin bad++; $display("FAIL rst_mid_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i] !== 8'h63 + 8'(i)) begin
        bad++; $display("FAIL rst_mid_order[%0d] got=%h exp=%h", i, got[i], 8'h63 + 8'(i));
      end
    end
  endtask

  task automatic test_error();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_idle got=%b exp=0", err_o); end
    errorEmpty = 1'b1;
    tick();
    errorEmpty = 1'b0;
    tick(); tick(); tick();
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_o); end
  endtask

`ifdef FIFO_READER_COUNT_EN
  task automatic test_count();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (word_count !== 4'd0) begin bad++; $display("FAIL count_reset got=%0d exp=0", word_count); end
    got.delete();
    ready_i = 1'b1; en = 1'b1;
    load(8'h70, 17);
    run_until(17, 60);
    tick();
    total++; if (got.size() != 17) begin bad++; $display("FAIL count_words got=%0d exp=17", got.size()); end
    total++; if (word_count !== 4'd1) begin bad++; $display("FAIL count_wrap got=%0d exp=1", word_count); end
  endtask
`endif

  initial begin
    rd_cnt = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_en_drop();
    test_reset_mid();
    test_error();
`ifdef FIFO_READER_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the 8-bit synchronous FIFO. It drains the FIFO by issuing `rd` pulses whenever the FIFO is non-empty and there is downstream space. It absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer and presents the words on a valid/ready stream. It sits between the FIFO's output port and the consuming block, and replaces hand-driven `rd` sequencing.

## Interface
Parameters:
- `DATA_WIDTH`, 8, FIFO word width
- `COUNT_WIDTH`, 16, width of the delivered-word counter (only with `FIFO_READER_COUNT_EN`)

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `en`  input  1  enables new reads; at 0 no new `rd`, but buffered and in-flight words still drain
- `outEmpty`  input  1  FIFO empty flag, updated on the same edge that samples `rd`
- `errorEmpty`  input  1  FIFO underflow error flag
- `data_out`  input  DATA_WIDTH  FIFO read data, valid the cycle after `rd` was sampled
- `rd`  output  1  FIFO read strobe
- `data_o`  output  DATA_WIDTH  head word of skid buffer
- `valid_o`  output  1  `data_o` holds a word
- `ready_i`  input  1  downstream accepts `data_o` this cycle
- `err_o`  output  1  sticky: FIFO underflow observed
- `word_count`  output  COUNT_WIDTH  words delivered (only with `FIFO_READER_COUNT_EN`)

## Operation
- State: buffer occupancy `occ` in {EMPTY=0, ONE=1, TWO=2}, in-flight flag `inflight` (a `rd` was sampled last edge), and buffer registers `buf0` (head) and `buf1`.
- `rd` is combinational: `en & ~outEmpty & ~reset & (occ + inflight - pop < 2)`, where `pop = valid_o & ready_i`. `rd` never exceeds the free space, so overflow of the skid buffer is impossible.
- On each edge, `inflight <= rd`.
- Push: if `inflight`=1, then `data_out` is written at the tail (`buf0` if the post-pop occupancy is 0, else `buf1`).
- Pop: if `pop`=1, `buf1` shifts to `buf0`.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved. With `occ`=1, the pushed word lands in `buf0` after the pop.
- Transitions:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - TWO -> ONE on pop. A push cannot occur in TWO.
- `valid_o = (occ != 0)`. `data_o = buf0`, which holds its value while `valid_o & ~ready_i`. The stream is strictly FIFO-ordered with no loss or duplication.
- `err_o` is set when `errorEmpty`=1 is sampled. It is cleared only by `reset`.
- `en` falling mid-burst: an in-flight word is still captured. Only new `rd` is blocked.

## Timing
- Reset values: `rd`=0, `valid_o`=0, `err_o`=0, `occ`=EMPTY, `inflight`=0, `data_o`=0, `word_count`=0.
- Reset mid-operation discards buffered and in-flight words. `rd` is 0 during the reset cycle.
- Latency: `rd` is sampled at edge N, `data_out` is captured at edge N+1, and `valid_o`=1 after edge N+1. A word therefore takes 2 cycles from FIFO non-empty to `valid_o`.
- Throughput: 1 word/cycle sustained when `ready_i`=1 and the FIFO is non-empty.
- After `ready_i` drops, at most 2 words are held. `rd` stops in the same cycle the credit limit is reached.
- A FIFO holding exactly 1 word: `outEmpty` rises at edge N, so no second `rd` is issued at N+1.

## Configuration
- `FIFO_READER_COUNT_EN` defined:
  - `word_count` port exists.
  - It increments by 1 on every `pop` and wraps from 2^COUNT_WIDTH-1 to 0.
- Undefined: the port and the counter are removed. All other behaviour is identical.

## Test plan
- Reset, then FIFO preloaded with 0x11,0x22,0x33, `en`=1, `ready_i`=1 -> `rd` high for 3 cycles. `valid_o` appears 2 cycles after the first `rd`. `data_o` sequence is 0x11,0x22,0x33 on consecutive cycles, then `valid_o`=0.
- Backpressure: 5 words preloaded, `ready_i`=0 -> exactly 2 `rd` pulses and `occ`=TWO, with `data_o`=first word stable. Then raise `ready_i` -> all 5 words delivered in order with no gaps after the first.
- Simultaneous push/pop: with `occ`=1, alternate `ready_i` 1/0 every cycle against a continuous supply -> order preserved and never more than 2 outstanding words (`occ + inflight`).
- `en` dropped while `inflight`=1 -> that word is still delivered and no further `rd` occurs. Re-raising `en` resumes reads.
- Reset asserted with `occ`=2 and `inflight`=1 -> next cycle `valid_o`=0 and `rd`=0. Discarded words never appear on `data_o`.
- `errorEmpty` pulsed for 1 cycle -> `err_o`=1 and held until reset.
- With `FIFO_READER_COUNT_EN` and `COUNT_WIDTH`=4: after 17 pops, `word_count`=1.
